// File: rtl/cnt_bank_pkg.sv
// Shared types and default parameters for the cnt_bank counter bank.
// Optional feature macro: CNT_BANK_SAT_EN (saturating counters instead of modulo wrap).
package cnt_bank_pkg;

  typedef enum logic {
    CNT_UP   = 1'b0,
    CNT_DOWN = 1'b1
  } dir_e;

  localparam int unsigned CNT_BANK_WIDTH_DEF = 64;
  localparam int unsigned CNT_BANK_NCH_DEF   = 2;
  localparam int unsigned CNT_BANK_DIV_DEF   = 4;

endpackage

// File: rtl/cnt_bank_chan.sv
// One counter channel: prescaler, up/down counter and one-cycle terminal-count pulse.
// CNT_BANK_SAT_EN selects saturation at the limits instead of modulo wrap.
module cnt_bank_chan
  import cnt_bank_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_BANK_WIDTH_DEF,
  parameter int unsigned DIV   = CNT_BANK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             act,
  input  logic             clr,
  input  dir_e             dir,
  input  logic             div,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] pre_nxt_c;
  logic             adv_c;
  logic             lim_c;
  logic [WIDTH-1:0] step_c;
  logic [WIDTH-1:0] cnt_nxt_c;
  logic             tc_nxt_c;

  // Prescale phase and whether this edge advances the counter
  always_comb begin
    pre_nxt_c = pre;
    adv_c     = 1'b0;
    if (act) begin
      if (!div || pre == PRE_LAST) begin
        pre_nxt_c = '0;
        adv_c     = 1'b1;
      end else begin
        pre_nxt_c = pre + PRE_W'(1);
      end
    end
  end

  // Next count and terminal-count pulse; lim_c marks the value an advance would wrap from
  always_comb begin
    lim_c     = (dir == CNT_DOWN) ? (cnt == '0) : (&cnt);
    step_c    = (dir == CNT_DOWN) ? (cnt - WIDTH'(1)) : (cnt + WIDTH'(1));
    cnt_nxt_c = cnt;
    tc_nxt_c  = 1'b0;
    if (adv_c) begin
`ifdef CNT_BANK_SAT_EN
      if (!lim_c) begin
        cnt_nxt_c = step_c;
        tc_nxt_c  = (dir == CNT_DOWN) ? (step_c == '0) : (&step_c);
      end
`else
      cnt_nxt_c = step_c;
      tc_nxt_c  = lim_c;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
      pre <= '0;
      tc  <= 1'b0;
    end else begin
      cnt <= cnt_nxt_c;
      pre <= pre_nxt_c;
      tc  <= tc_nxt_c;
    end
  end

endmodule

// File: rtl/cnt_bank.sv
// Multi-channel event counter bank: decodes the channel select into per-channel
// activate/clear strobes. Optional macro CNT_BANK_SAT_EN makes every channel saturate.
module cnt_bank
  import cnt_bank_pkg::*;
#(
  parameter  int unsigned WIDTH = CNT_BANK_WIDTH_DEF,
  parameter  int unsigned NCH   = CNT_BANK_NCH_DEF,
  parameter  int unsigned DIV   = CNT_BANK_DIV_DEF,
  localparam int unsigned SEL_W = $clog2(NCH)
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 En,
  input  logic [SEL_W-1:0]     Slt,
  input  logic                 Dir,
  input  logic                 Div,
  input  logic                 Clr,
  output logic [NCH*WIDTH-1:0] Output,
  output logic [NCH-1:0]       Tc
);

  logic [NCH-1:0] act_c;
  logic [NCH-1:0] clr_c;

  // Out-of-range selects match no channel, so they neither count nor clear
  always_comb begin
    act_c = '0;
    clr_c = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (Slt == SEL_W'(i)) begin
        clr_c[i] = Clr;
        act_c[i] = En && !Clr;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    cnt_bank_chan #(
      .WIDTH(WIDTH),
      .DIV  (DIV)
    ) u_chan (
      .clk  (Clk),
      .reset(Reset),
      .act  (act_c[g]),
      .clr  (clr_c[g]),
      .dir  (dir_e'(Dir)),
      .div  (Div),
      .cnt  (Output[g*WIDTH +: WIDTH]),
      .tc   (Tc[g])
    );
  end

endmodule

// File: tb/tb_cnt_bank.sv
// Directed, table-driven bench for cnt_bank at WIDTH=8, NCH=2, DIV=4.
// Expected values follow the CNT_BANK_SAT_EN setting of the build.
module tb_cnt_bank;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NCH   = 2;
  localparam int unsigned DIV   = 4;
`ifdef CNT_BANK_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic                 Clk = 1'b0;
  logic                 Reset, En, Dir, Div, Clr;
  logic [0:0]           Slt;
  logic [NCH*WIDTH-1:0] Output;
  logic [NCH-1:0]       Tc;

  cnt_bank #(.WIDTH(WIDTH), .NCH(NCH), .DIV(DIV)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .En    (En),
    .Slt   (Slt),
    .Dir   (Dir),
    .Div   (Div),
    .Clr   (Clr),
    .Output(Output),
    .Tc    (Tc)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst, en, slt, dir, dv, clr;
    int         n;
    int         e0, e1;
    logic [1:0] etc;
    int         c0, c1;
  } vec_t;

  localparam int NV = 19;
  vec_t tab[NV];
  int nchk = 0;
  int nbad = 0;

  function automatic vec_t mk(logic rst, logic en, logic slt, logic dir, logic dv, logic clr,
                              int n, int e0, int e1, logic [1:0] etc, int c0, int c1);
    vec_t v;
    v.rst = rst; v.en = en; v.slt = slt; v.dir = dir; v.dv = dv; v.clr = clr;
    v.n = n; v.e0 = e0; v.e1 = e1; v.etc = etc; v.c0 = c0; v.c1 = c1;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input int got, input int want);
    nchk++;
    if (got != want) begin
      nbad++;
      $display("FAIL %s[%0d] got=%0d want=%0d", name, idx, got, want);
    end
  endtask

  task automatic drive(input vec_t v);
    Reset = v.rst; En = v.en; Slt = v.slt; Dir = v.dir; Div = v.dv; Clr = v.clr;
  endtask

  initial begin
    int t0, t1;
    //            rst en slt dir div clr   n   ch0              ch1          tc_last                 cnt0  cnt1
    tab[0]  = mk(1, 0, 0, 0, 0, 0,   1,   0,               0,           2'b00,                  0, 0);
    tab[1]  = mk(0, 1, 0, 0, 0, 0,  20,  20,               0,           2'b00,                  0, 0);
    tab[2]  = mk(0, 1, 1, 0, 1, 0,  40,  20,              10,           2'b00,                  0, 0);
    tab[3]  = mk(0, 0, 1, 0, 1, 0,  10,  20,              10,           2'b00,                  0, 0);
    tab[4]  = mk(0, 1, 0, 0, 0, 0, 236, SAT ? 255 : 0,    10,           SAT ? 2'b00 : 2'b01,    1, 0);
    tab[5]  = mk(0, 1, 1, 0, 0, 1,   1, SAT ? 255 : 0,     0,           2'b00,                  0, 0);
    tab[6]  = mk(0, 1, 1, 1, 0, 0,   1, SAT ? 255 : 0,    SAT ? 0 : 255, SAT ? 2'b00 : 2'b10,   0, SAT ? 0 : 1);
    tab[7]  = mk(0, 1, 1, 0, 1, 0,   2, SAT ? 255 : 0,    SAT ? 0 : 255, 2'b00,                 0, 0);
    tab[8]  = mk(0, 1, 1, 0, 1, 1,   1, SAT ? 255 : 0,     0,           2'b00,                  0, 0);
    tab[9]  = mk(0, 1, 1, 0, 1, 0,   3, SAT ? 255 : 0,     0,           2'b00,                  0, 0);
    tab[10] = mk(0, 1, 1, 0, 1, 0,   1, SAT ? 255 : 0,     1,           2'b00,                  0, 0);
    tab[11] = mk(0, 1, 1, 0, 1, 0,   3, SAT ? 255 : 0,     1,           2'b00,                  0, 0);
    tab[12] = mk(1, 1, 1, 0, 1, 0,   1,   0,               0,           2'b00,                  0, 0);
    tab[13] = mk(0, 1, 1, 0, 1, 0,   3,   0,               0,           2'b00,                  0, 0);
    tab[14] = mk(0, 1, 1, 0, 1, 0,   1,   0,               1,           2'b00,                  0, 0);
    tab[15] = mk(0, 1, 0, 1, 0, 0,   5, SAT ? 0 : 251,     1,           2'b00,                  SAT ? 0 : 1, 0);
    tab[16] = mk(0, 1, 1, 0, 1, 0,   2, SAT ? 0 : 251,     1,           2'b00,                  0, 0);
    tab[17] = mk(0, 1, 0, 0, 0, 0,   1, SAT ? 1 : 252,     1,           2'b00,                  0, 0);
    tab[18] = mk(0, 1, 1, 0, 1, 0,   2, SAT ? 1 : 252,     2,           2'b00,                  0, 0);

    Reset = 1'b1; En = 1'b0; Slt = 1'b0; Dir = 1'b0; Div = 1'b0; Clr = 1'b0;
    @(posedge Clk); #1;

    for (int i = 0; i < NV; i++) begin
      drive(tab[i]);
      t0 = 0; t1 = 0;
      for (int k = 0; k < tab[i].n; k++) begin
        @(posedge Clk); #1;
        t0 += int'(Tc[0]);
        t1 += int'(Tc[1]);
      end
      check("ch0", i, int'(Output[7:0]),  tab[i].e0);
      check("ch1", i, int'(Output[15:8]), tab[i].e1);
      check("tc",  i, int'(Tc),           int'(tab[i].etc));
      check("tc0_pulses", i, t0, tab[i].c0);
      check("tc1_pulses", i, t1, tab[i].c1);
    end

    // Tc must coincide cycle-for-cycle with the limit value appearing on ch0
    begin
      int seq_n;
      int exp_cnt[5];
      int exp_tc[5];
      if (SAT) begin
        seq_n = 3;
        exp_cnt = '{0, 0, 0, 0, 0};
        exp_tc  = '{1, 0, 0, 0, 0};
        Dir = 1'b1;
      end else begin
        seq_n = 5;
        exp_cnt = '{253, 254, 255, 0, 1};
        exp_tc  = '{0, 0, 0, 1, 0};
        Dir = 1'b0;
      end
      Reset = 1'b0; En = 1'b1; Slt = 1'b0; Div = 1'b0; Clr = 1'b0;
      for (int k = 0; k < seq_n; k++) begin
        @(posedge Clk); #1;
        check("seq_ch0", k, int'(Output[7:0]), exp_cnt[k]);
        check("seq_tc0", k, int'(Tc[0]),       exp_tc[k]);
        check("seq_ch1", k, int'(Output[15:8]), 2);
      end
    end

    // Enable dropped mid-prescale: phase is kept, only enabled edges count
    Slt = 1'b1; Dir = 1'b0; Div = 1'b1; En = 1'b1;
    @(posedge Clk); #1;
    En = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    En = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check("hold_pre_ch1", 0, int'(Output[15:8]), 2);
    @(posedge Clk); #1;
    check("hold_pre_ch1", 1, int'(Output[15:8]), 3);
    check("hold_pre_tc",  1, int'(Tc), 0);

    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
